// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The producer/monitor side uses master; the serializer uses slave.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             enable;
    logic             out_bit;
    logic             out_valid;
    logic             word_start;
    logic             busy;

    modport master (
        output in_data, in_valid, enable,
        input  in_ready, out_bit, out_valid, word_start, busy
    );

    modport slave (
        input  in_data, in_valid, enable,
        output in_ready, out_bit, out_valid, word_start, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register, so that
// back-to-back words stream without a gap cycle.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int IDLE_BIT  = 0
) (
    input  logic          clk,
    input  logic          reset,
    bit_serializer_if.slave bus
);
    localparam int   CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic IDLE_B = 1'(IDLE_BIT);
    localparam logic MSB_F  = (MSB_FIRST != 0);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, hold, shreg_shifted;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             shift_en, last, accept, free;
    logic             load_direct, load_hold, move_hold;
    logic             head;

    assign last          = (cnt == CW'(WIDTH - 1));
    assign head          = MSB_F ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = MSB_F ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        shift_en       = 1'b0;
        free           = 1'b0;
        accept         = bus.in_valid && !hold_full;
        bus.in_ready   = !hold_full;
        case (state)
            IDLE: begin
                free = 1'b1;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_en = bus.enable;
                // The shifter frees up only when its last bit leaves and nothing is waiting.
                free     = shift_en && last && !hold_full;
                if (free && !accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        load_direct    = accept && free;
        load_hold      = accept && !free;
        move_hold      = shift_en && last && hold_full;
        bus.out_valid  = shift_en;
        bus.out_bit    = shift_en ? head : IDLE_B;
        bus.word_start = shift_en && (cnt == '0);
        bus.busy       = (state == SHIFT) || hold_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            if (load_direct) begin
                shreg <= bus.in_data;
                cnt   <= '0;
            end else if (move_hold) begin
                shreg <= hold;
                cnt   <= '0;
            end else if (shift_en) begin
                shreg <= shreg_shifted;
                cnt   <= last ? '0 : cnt + CW'(1);
            end
            if (load_hold) begin
                hold      <= bus.in_data;
                hold_full <= 1'b1;
            end else if (move_hold) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances.
module tb_bit_serializer;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    bit_serializer_if #(.WIDTH(8)) b0 ();
    bit_serializer_if #(.WIDTH(8)) b1 ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(0)) u1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  exp8;
    logic [7:0]  got8;
    logic [15:0] got16;
    logic [3:0]  det;
    logic        seen;
    int          nv, nlow, nws;
    logic        en;

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        b0.in_data = '0; b0.in_valid = 1'b0; b0.enable = 1'b1;
        b1.in_data = '0; b1.in_valid = 1'b0; b1.enable = 1'b1;
        #2;
        // {in_ready, out_valid, out_bit, word_start, busy}
        chk("rst_u0", {b0.in_ready, b0.out_valid, b0.out_bit, b0.word_start, b0.busy}, 5'b10000);
        chk("rst_u1", {b1.in_ready, b1.out_valid, b1.out_bit, b1.word_start, b1.busy}, 5'b10000);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("post_rst", {b0.in_ready, b0.out_valid, b0.out_bit, b0.word_start, b0.busy}, 5'b10000);

        // Single word 0xB0, MSB first
        exp8 = 8'b1011_0000;
        b0.in_data = 8'hB0; b0.in_valid = 1'b1;
        #1;
        chk("t1_ready", b0.in_ready, 1);
        tick();
        b0.in_valid = 1'b0;
        det = '0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", b0.out_valid, 1);
            chk("t1_bit", b0.out_bit, exp8[7-i]);
            chk("t1_ws", b0.word_start, (i == 0));
            det = {det[2:0], b0.out_bit};
            if (det == 4'b1011) seen = 1'b1;
            tick();
        end
        chk("t1_det1011", seen, 1);
        chk("t1_done", {b0.out_valid, b0.busy, b0.in_ready}, 3'b001);

        // Back-to-back 0xB0, 0x0B
        b0.in_data = 8'hB0; b0.in_valid = 1'b1;
        tick();
        got16 = '0; nv = 0; nlow = 0; nws = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) b0.in_data = 8'h0B;
            if (i == 1) b0.in_valid = 1'b0;
            if (i == 1) chk("t2_rdy_lo", b0.in_ready, 0);
            if (i == 8) chk("t2_rdy_hi", b0.in_ready, 1);
            if (b0.out_valid) begin
                nv++;
                got16 = {got16[14:0], b0.out_bit};
            end
            if (!b0.in_ready) nlow++;
            if (b0.word_start) nws++;
            tick();
        end
        chk("t2_bits", got16, 16'hB00B);
        chk("t2_nvalid", nv, 16);
        chk("t2_ready_low", nlow, 7);
        chk("t2_nws", nws, 2);
        chk("t2_done", {b0.out_valid, b0.busy}, 2'b00);

        // Stall for 3 cycles after bit 2
        b0.in_data = 8'hB0; b0.in_valid = 1'b1;
        tick();
        b0.in_valid = 1'b0;
        got8 = '0; nv = 0; nws = 0;
        for (int i = 0; i < 11; i++) begin
            en = !(i >= 2 && i < 5);
            b0.enable = en;
            #1;
            if (!en) chk("t3_stall", {b0.out_valid, b0.out_bit}, 2'b00);
            if (!en) chk("t3_stall_busy", b0.busy, 1);
            if (b0.out_valid) begin
                nv++;
                got8 = {got8[6:0], b0.out_bit};
            end
            if (b0.word_start) nws++;
            tick();
        end
        b0.enable = 1'b1;
        #1;
        chk("t3_bits", got8, 8'hB0);
        chk("t3_nvalid", nv, 8);
        chk("t3_nws", nws, 1);
        chk("t3_done", {b0.out_valid, b0.busy}, 2'b00);

        // LSB-first instance, 0x0D
        exp8 = 8'b1011_0000;
        b1.in_data = 8'h0D; b1.in_valid = 1'b1;
        tick();
        b1.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_valid", b1.out_valid, 1);
            chk("t4_bit", b1.out_bit, exp8[7-i]);
            tick();
        end
        chk("t4_done", {b1.out_valid, b1.busy}, 2'b00);

        // Reset mid-word with a second word held
        b0.in_data = 8'hFF; b0.in_valid = 1'b1;
        tick();
        b0.in_data = 8'h55;
        tick();
        b0.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t5_pre_busy", {b0.busy, b0.in_ready, b0.out_valid}, 3'b101);
        reset = 1'b1;
        #1;
        chk("t5_rst", {b0.in_ready, b0.out_valid, b0.out_bit, b0.word_start, b0.busy}, 5'b10000);
        tick(); tick();
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (b0.out_valid || b0.busy) nv++;
            tick();
        end
        chk("t5_no_resume", nv, 0);

        // Long idle
        for (int i = 0; i < 20; i++) begin
            chk("t6_idle", {b0.out_valid, b0.out_bit, b0.busy, b0.in_ready}, 4'b0001);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, the number of bits per parallel word (minimum 2).
REQ-002 Parameter: MSB_FIRST, default 1; 1 shifts bit WIDTH-1 out first, 0 shifts bit 0 out first.
REQ-003 Parameter: IDLE_BIT, default 0, the value driven on out_bit whenever out_valid is 0.
REQ-004 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: in_data  input  WIDTH  the parallel word offered by the producer.
REQ-007 Port: in_valid  input  1  the producer asserts this when in_data holds a word.
REQ-008 Port: in_ready  output  1  the block can accept a word this cycle.
REQ-009 Port: enable  input  1  shift enable; when low, the block stalls the serial stream.
REQ-010 Port: out_bit  output  1  the serial bit; it drives the downstream sequence detector's inp_bit.
REQ-011 Port: out_valid  output  1  out_bit carries a word bit this cycle.
REQ-012 Port: word_start  output  1  high during the first bit of each word.
REQ-013 Port: busy  output  1  high when the shifter or the holding register contains data.

Function
REQ-014 Storage SHALL be one WIDTH-bit shift register, one WIDTH-bit holding register with a full flag, and a bit counter of width ceil(log2(WIDTH)).
REQ-015 Shifter FSM SHALL have exactly two states: IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-016 in_ready SHALL equal NOT hold_full; it is combinational from state only and never depends on in_valid.
REQ-017 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no word is accepted otherwise.
REQ-018 An accepted word SHALL load directly into the shifter if the shifter is free at that edge; otherwise it SHALL load into the holding register.
REQ-019 The shifter is free at an edge if (a) state=IDLE, or (b) state=SHIFT with enable=1, bit counter at the last bit, and hold_full=0.
REQ-020 On the edge where the last bit shifts with enable=1 and hold_full=1, the holding word SHALL move into the shifter and hold_full SHALL clear; the block stays in SHIFT, leaving no gap cycle.
REQ-021 On the edge where the last bit shifts with no pending word and no accept, the FSM SHALL go to IDLE.
REQ-022 Latency: the first bit of a word loaded directly SHALL appear on out_bit in the cycle immediately after the accept edge.
REQ-023 In SHIFT with enable=1: out_valid=1, out_bit is the current head bit, and the counter and shifter advance on each edge.
REQ-024 In SHIFT with enable=0: out_valid=0, out_bit=IDLE_BIT, and the shifter, counter and holding register hold their values; word acceptance into an empty holding register is still allowed.
REQ-025 In IDLE: out_valid=0 and out_bit=IDLE_BIT.
REQ-026 word_start SHALL equal out_valid AND (counter at first bit).
REQ-027 busy SHALL equal (state=SHIFT) OR hold_full.
REQ-028 Each word SHALL produce exactly WIDTH cycles with out_valid=1; no bit is dropped or duplicated across stalls.

Reset
REQ-029 While reset=1 (asynchronously): state=IDLE, hold_full=0, counter=0, and shift and holding registers=0.
REQ-030 During and after reset: in_ready=1, out_valid=0, out_bit=IDLE_BIT, word_start=0, busy=0.
REQ-031 Reset asserted mid-word SHALL discard the partial word and any held word; output resumes only after a new accept.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, enable=1: accept 0xB0 -> out_bit 1,0,1,1,0,0,0,0 over 8 consecutive out_valid cycles, with word_start on the first; the downstream detector flags 1011.
REQ-033 Back-to-back 0xB0 then 0x0B, in_valid held -> 16 contiguous out_valid cycles; in_ready low for exactly 7 cycles, from the edge after the second accept until the hold-to-shifter move.
REQ-034 MSB_FIRST=0, accept 0x0D -> out_bit 1,0,1,1,0,0,0,0.
REQ-035 0xB0, with enable dropped for 3 cycles after bit 2 -> out_valid=0 and out_bit=0 for those 3 cycles, then bits 1,1,0,0,0,0 resume; total valid count 8.
REQ-036 Reset pulsed after bit 4 of 0xFF, with a second word held -> immediately out_valid=0, busy=0, in_ready=1; no further bits until a new accept.
REQ-037 Idle with in_valid=0 for 20 cycles -> out_valid=0, out_bit=IDLE_BIT, busy=0, in_ready=1 throughout.
